// File: rtl/conv_kernel_engine.sv
// rtl/conv_kernel_engine.sv - streaming KxK signed-kernel convolution engine with zero-padded borders
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, abort             frame start pulse (IDLE only), return-to-IDLE from any state
//   mode, shift              output mode and arithmetic right shift, captured at start
//   coef_we/index/data       kernel tap write port, row-major index, IDLE only
//   pixel_in*                raster input stream (valid/ready)
//   pixel_out*               filtered output stream (valid/ready), one pixel per input pixel
//   busy, frame_done         high in RUN/FLUSH; one-cycle pulse in DONE
module conv_kernel_engine #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int PIXEL_WIDTH  = 8,
    parameter int KERNEL_EDGE  = 3,
    parameter int COEF_WIDTH   = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic                                       abort,
    input  logic [1:0]                                 mode,
    input  logic [3:0]                                 shift,
    input  logic                                       coef_we,
    input  logic [$clog2(KERNEL_EDGE*KERNEL_EDGE)-1:0] coef_index,
    input  logic [COEF_WIDTH-1:0]                      coef_data,
    input  logic [PIXEL_WIDTH-1:0]                     pixel_in,
    input  logic                                       pixel_in_valid,
    output logic                                       pixel_in_ready,
    output logic [PIXEL_WIDTH-1:0]                     pixel_out,
    output logic                                       pixel_out_valid,
    input  logic                                       pixel_out_ready,
    output logic                                       busy,
    output logic                                       frame_done
);
    localparam int R      = (KERNEL_EDGE - 1) / 2;
    localparam int NTAPS  = KERNEL_EDGE * KERNEL_EDGE;
    localparam int HIST   = (KERNEL_EDGE - 1) * IMAGE_WIDTH + KERNEL_EDGE - 1;
    localparam int PRIME  = R * IMAGE_WIDTH + R;
    localparam int PROD_W = PIXEL_WIDTH + 1 + COEF_WIDTH;
    localparam int ACC_W  = PROD_W + $clog2(NTAPS);
    localparam int COL_W  = $clog2(IMAGE_WIDTH);
    localparam int ROW_W  = $clog2(IMAGE_HEIGHT);
    localparam int FILL_W = $clog2(PRIME + 1);
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIXEL_WIDTH) - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                        state, state_next;
    logic signed [COEF_WIDTH-1:0]  coef [NTAPS];
    logic [PIXEL_WIDTH-1:0]        hist [HIST];
    logic [PIXEL_WIDTH-1:0]        tap_pix [NTAPS];
    logic [COL_W-1:0]              in_col, out_col;
    logic [ROW_W-1:0]              in_row, out_row;
    logic [FILL_W-1:0]             fill_cnt, flush_cnt;
    logic [1:0]                    mode_q;
    logic [3:0]                    shift_q;
    logic                          out_last;

    logic                          stall_free, accept, inject, step, primed, last_in, last_out_taken;
    logic [PIXEL_WIDTH-1:0]        step_pixel, result;
    logic signed [PROD_W-1:0]      prod;
    logic signed [ACC_W-1:0]       acc, shifted, mag;

    assign stall_free     = !pixel_out_valid || pixel_out_ready;
    assign pixel_in_ready = (state == RUN) && stall_free;
    assign accept         = pixel_in_valid && pixel_in_ready;
    assign inject         = (state == FLUSH) && stall_free && (flush_cnt < FILL_W'(PRIME));
    assign step           = accept || inject;
    assign step_pixel     = accept ? pixel_in : '0;
    assign primed         = (fill_cnt == FILL_W'(PRIME));
    assign last_in        = accept && (in_row == ROW_W'(IMAGE_HEIGHT - 1))
                                   && (in_col == COL_W'(IMAGE_WIDTH - 1));
    assign last_out_taken = pixel_out_valid && pixel_out_ready && out_last;
    assign busy           = (state == RUN) || (state == FLUSH);
    assign frame_done     = (state == DONE);

    // The history is one long raster-order shift register: tap (i,j) sits a
    // fixed distance behind the pixel being stepped in this cycle, distance 0
    // being that pixel itself.
    for (genvar gi = 0; gi < KERNEL_EDGE; gi++) begin : g_row
        for (genvar gj = 0; gj < KERNEL_EDGE; gj++) begin : g_col
            localparam int DIST = (2 * R - gi) * IMAGE_WIDTH + (2 * R - gj);
            if (DIST == 0) begin : g_new
                assign tap_pix[gi*KERNEL_EDGE+gj] = step_pixel;
            end else begin : g_old
                assign tap_pix[gi*KERNEL_EDGE+gj] = hist[DIST-1];
            end
        end
    end

    // Taps whose source falls outside the frame are dropped; this also kills
    // the raster wrap between the end of one line and the start of the next.
    always_comb begin
        acc  = '0;
        prod = '0;
        for (int i = 0; i < KERNEL_EDGE; i++) begin
            for (int j = 0; j < KERNEL_EDGE; j++) begin
                if ((int'(out_row) + i - R >= 0) && (int'(out_row) + i - R < IMAGE_HEIGHT) &&
                    (int'(out_col) + j - R >= 0) && (int'(out_col) + j - R < IMAGE_WIDTH)) begin
                    prod = PROD_W'(signed'({1'b0, tap_pix[i*KERNEL_EDGE+j]}))
                         * PROD_W'(coef[i*KERNEL_EDGE+j]);
                    acc  = acc + ACC_W'(prod);
                end
            end
        end
    end

    always_comb begin
        shifted = acc >>> shift_q;
        mag     = shifted[ACC_W-1] ? -shifted : shifted;
        result  = '0;
        case (mode_q)
            2'd1: begin
                if (shifted[ACC_W-1])      result = '0;
                else if (shifted > PIX_MAX) result = '1;
                else                        result = shifted[PIXEL_WIDTH-1:0];
            end
            2'd2: begin
                if (mag > PIX_MAX) result = '1;
                else               result = mag[PIXEL_WIDTH-1:0];
            end
            default: result = tap_pix[NTAPS/2];
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)          state_next = RUN;
            RUN:     if (last_in)        state_next = FLUSH;
            FLUSH:   if (last_out_taken) state_next = DONE;
            DONE:                        state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            in_col          <= '0;
            in_row          <= '0;
            out_col         <= '0;
            out_row         <= '0;
            fill_cnt        <= '0;
            flush_cnt       <= '0;
            mode_q          <= '0;
            shift_q         <= '0;
            out_last        <= 1'b0;
            pixel_out       <= '0;
            pixel_out_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (abort) begin
                pixel_out_valid <= 1'b0;
            end else if (state == IDLE && start) begin
                mode_q          <= mode;
                shift_q         <= shift;
                in_col          <= '0;
                in_row          <= '0;
                out_col         <= '0;
                out_row         <= '0;
                fill_cnt        <= '0;
                flush_cnt       <= '0;
                out_last        <= 1'b0;
                pixel_out_valid <= 1'b0;
            end else begin
                if (accept) begin
                    if (in_col == COL_W'(IMAGE_WIDTH - 1)) begin
                        in_col <= '0;
                        in_row <= in_row + 1'b1;
                    end else begin
                        in_col <= in_col + 1'b1;
                    end
                end
                if (inject) flush_cnt <= flush_cnt + 1'b1;
                if (step && primed) begin
                    pixel_out <= result;
                    out_last  <= (out_row == ROW_W'(IMAGE_HEIGHT - 1)) &&
                                 (out_col == COL_W'(IMAGE_WIDTH - 1));
                    if (out_col == COL_W'(IMAGE_WIDTH - 1)) begin
                        out_col <= '0;
                        out_row <= out_row + 1'b1;
                    end else begin
                        out_col <= out_col + 1'b1;
                    end
                end else if (step) begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
                if (step && primed)                          pixel_out_valid <= 1'b1;
                else if (pixel_out_valid && pixel_out_ready) pixel_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < HIST; k++) hist[k] <= '0;
        end else if (step) begin
            hist[0] <= step_pixel;
            for (int k = 1; k < HIST; k++) hist[k] <= hist[k-1];
        end
    end

    // Coefficients survive abort; they reload as identity only on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) coef[k] <= (k == NTAPS / 2) ? COEF_WIDTH'(1) : '0;
        end else if (state == IDLE && coef_we && int'(coef_index) < NTAPS) begin
            coef[coef_index] <= coef_data;
        end
    end
endmodule
